// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Multi-cycle IF/ID/EX/MEM/WB sequencer for the teaching datapath.
//               Owns the IM address, gates the RF/DM write strobes to their
//               own phase and provides run / pause / single-step / halt
//               control from board switches and buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
    parameter int INSTR_NUM  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_en,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic                  wrap_en,
    input  logic                  reg_write,
    input  logic                  mem_write,
    input  logic                  is_load,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [2:0]            state_o,
    output logic                  ir_we,
    output logic                  rf_we,
    output logic                  dm_we,
    output logic                  instr_done,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired_cnt
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_IF   = 3'd1;
    localparam logic [2:0] c_ST_ID   = 3'd2;
    localparam logic [2:0] c_ST_EX   = 3'd3;
    localparam logic [2:0] c_ST_MEM  = 3'd4;
    localparam logic [2:0] c_ST_WB   = 3'd5;
    localparam logic [2:0] c_ST_HALT = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_PC = ADDR_WIDTH'(INSTR_NUM - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [2:0]            w_ret_target;
    logic                  r_step_d;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_step_rise;
    logic                  w_go;
    logic                  w_last;

    assign w_step_rise = step_req & ~r_step_d;
    assign w_go        = run_en & (~step_mode | w_step_rise);
    assign w_last      = (r_pc == c_LAST_PC);

    assign pc_o        = r_pc;
    assign state_o     = r_state;
    assign retired_cnt = r_cnt;
    assign halted      = (r_state == c_ST_HALT);

    // Where the FSM goes after a retiring cycle: halt at the end of the
    // program, park in IDLE when stepping or paused, else fetch the next one.
    always_comb begin
        w_ret_target = c_ST_IF;
        if (w_last && !wrap_en) begin
            w_ret_target = c_ST_HALT;
        end else if (step_mode || !run_en) begin
            w_ret_target = c_ST_IDLE;
        end
    end

    // State register, step-button edge history, PC and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_step_d <= 1'b0;
            r_pc     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_step_d <= step_req;
            if (instr_done) begin
                if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // On halt the PC stays parked on the last instruction.
                if (!w_last) begin
                    r_pc <= r_pc + 1'b1;
                end else if (wrap_en) begin
                    r_pc <= '0;
                end
            end
        end
    end

    // Next-state decode; decode inputs are sampled live from ID onward.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_go) w_next_state = c_ST_IF;
            c_ST_IF:   w_next_state = c_ST_ID;
            c_ST_ID:   w_next_state = c_ST_EX;
            c_ST_EX:   w_next_state = (is_load || mem_write) ? c_ST_MEM : c_ST_WB;
            c_ST_MEM:  w_next_state = is_load ? c_ST_WB : w_ret_target;
            c_ST_WB:   w_next_state = w_ret_target;
            c_ST_HALT: w_next_state = c_ST_HALT;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Phase-gated strobes; reset suppresses every strobe and retire at once.
    always_comb begin
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        dm_we      = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            c_ST_IF: begin
                ir_we = ~rst;
            end
            c_ST_MEM: begin
                dm_we      = mem_write & ~rst;
                instr_done = ~is_load & ~rst;
            end
            c_ST_WB: begin
                rf_we      = reg_write & ~rst;
                instr_done = ~rst;
            end
            default: begin
                ir_we = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_ctrl
// Description : Directed self-checking bench for cpu_step_ctrl (4-entry
//               program, 3-bit retire counter so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

    localparam int INSTR_NUM  = 4;
    localparam int ADDR_WIDTH = 4;
    localparam int CNT_WIDTH  = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  run_en = 1'b0;
    logic                  step_mode = 1'b0;
    logic                  step_req = 1'b0;
    logic                  wrap_en = 1'b0;
    logic                  reg_write = 1'b0;
    logic                  mem_write = 1'b0;
    logic                  is_load = 1'b0;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic [2:0]            state_o;
    logic                  ir_we;
    logic                  rf_we;
    logic                  dm_we;
    logic                  instr_done;
    logic                  halted;
    logic [CNT_WIDTH-1:0]  retired_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cpu_step_ctrl #(
        .INSTR_NUM  (INSTR_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .run_en      (run_en),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .wrap_en     (wrap_en),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .is_load     (is_load),
        .pc_o        (pc_o),
        .state_o     (state_o),
        .ir_we       (ir_we),
        .rf_we       (rf_we),
        .dm_we       (dm_we),
        .instr_done  (instr_done),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strb();
        return 32'({ir_we, rf_we, dm_we, instr_done});
    endfunction

    initial begin
        int ph;
        int done_cnt;
        int bad;

        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_pc", 32'(pc_o), 0);
        chk("rst_cnt", 32'(retired_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_strb", strb(), 0);

        // Back-to-back ALU ops: IF ID EX WB, strobes {ir,rf,dm,done}
        rst = 1'b0; run_en = 1'b1; wrap_en = 1'b1; reg_write = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            ph = (c - 1) % 4;
            chk("alu_state", 32'(state_o), (ph == 3) ? 5 : ph + 1);
            chk("alu_strb", strb(), (ph == 0) ? 4'b1000 : (ph == 3) ? 4'b0101 : 4'b0000);
            chk("alu_pc", 32'(pc_o), (c - 1) / 4);
        end
        tick();
        chk("alu_end_state", 32'(state_o), 1);
        chk("alu_end_pc", 32'(pc_o), 3);
        chk("alu_end_cnt", 32'(retired_cnt), 3);

        // Load at last address: ID EX MEM WB, then wrap to 0
        is_load = 1'b1;
        tick(); chk("ld_id", 32'(state_o), 2); chk("ld_id_strb", strb(), 0);
        tick(); chk("ld_ex", 32'(state_o), 3); chk("ld_ex_strb", strb(), 0);
        tick(); chk("ld_mem", 32'(state_o), 4); chk("ld_mem_strb", strb(), 0);
        tick(); chk("ld_wb", 32'(state_o), 5); chk("ld_wb_strb", strb(), 4'b0101);
        tick();
        chk("ld_next_state", 32'(state_o), 1);
        chk("ld_wrap_pc", 32'(pc_o), 0);
        chk("ld_cnt", 32'(retired_cnt), 4);

        // Store with reg_write forced high: rf_we must stay low
        is_load = 1'b0; mem_write = 1'b1;
        tick(); chk("st_id_strb", strb(), 0);
        tick(); chk("st_ex", 32'(state_o), 3); chk("st_ex_strb", strb(), 0);
        tick(); chk("st_mem", 32'(state_o), 4); chk("st_mem_strb", strb(), 4'b0011);
        tick();
        chk("st_next_if", 32'(state_o), 1);
        chk("st_pc", 32'(pc_o), 1);
        chk("st_cnt", 32'(retired_cnt), 5);
        chk("st_if_strb", strb(), 4'b1000);

        // Pause: run_en drops during EX, instruction still retires
        mem_write = 1'b0;
        tick(); tick();
        chk("pz_ex", 32'(state_o), 3);
        run_en = 1'b0;
        tick(); chk("pz_wb", 32'(state_o), 5); chk("pz_wb_strb", strb(), 4'b0101);
        tick();
        chk("pz_idle", 32'(state_o), 0);
        chk("pz_pc", 32'(pc_o), 2);
        chk("pz_cnt", 32'(retired_cnt), 6);
        tick(); tick(); tick();
        chk("pz_idle_hold", 32'(state_o), 0);
        chk("pz_pc_hold", 32'(pc_o), 2);

        // Step held high for 20 cycles: exactly one instruction
        step_mode = 1'b1; run_en = 1'b1; step_req = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            tick();
            done_cnt += int'(instr_done);
        end
        chk("step_hold_retires", 32'(done_cnt), 1);
        chk("step_hold_state", 32'(state_o), 0);
        chk("step_hold_pc", 32'(pc_o), 3);
        chk("step_hold_cnt", 32'(retired_cnt), 7);

        // Second press during EX is ignored; counter saturates; pc wraps
        step_req = 1'b0; tick();
        step_req = 1'b1; tick(); chk("step2_if", 32'(state_o), 1);
        step_req = 1'b0; tick();
        tick(); chk("step2_ex", 32'(state_o), 3);
        step_req = 1'b1;
        tick(); chk("step2_wb", 32'(state_o), 5);
        tick();
        chk("step2_idle", 32'(state_o), 0);
        chk("step2_wrap_pc", 32'(pc_o), 0);
        chk("step2_cnt_sat", 32'(retired_cnt), 7);
        tick(); tick(); tick();
        chk("step2_not_queued", 32'(state_o), 0);

        // step_mode with run_en=0: presses ignored
        run_en = 1'b0; step_req = 1'b0; tick();
        step_req = 1'b1; tick(); tick();
        chk("step_norun_state", 32'(state_o), 0);
        chk("step_norun_pc", 32'(pc_o), 0);

        // Halt after the last instruction with wrap disabled
        rst = 1'b1; tick();
        chk("rst2_cnt", 32'(retired_cnt), 0);
        rst = 1'b0; step_mode = 1'b0; run_en = 1'b1; wrap_en = 1'b0; step_req = 1'b0;
        done_cnt = 0;
        repeat (17) begin
            tick();
            done_cnt += int'(instr_done);
        end
        chk("halt_retires", 32'(done_cnt), 4);
        chk("halt_state", 32'(state_o), 6);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", 32'(pc_o), 3);
        chk("halt_cnt", 32'(retired_cnt), 4);
        bad = 0;
        mem_write = 1'b1;
        repeat (50) begin
            tick();
            step_req = ~step_req;
            is_load  = ~is_load;
            if (state_o !== 3'd6 || strb() !== 32'd0 || pc_o !== 4'd3 || halted !== 1'b1)
                bad++;
        end
        chk("halt_hold_bad_cycles", 32'(bad), 0);

        // Reset during a store's MEM cycle
        rst = 1'b1; tick();
        rst = 1'b0; mem_write = 1'b1; is_load = 1'b0; reg_write = 1'b0;
        wrap_en = 1'b1; step_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rm_mem1_strb", strb(), 4'b0011);
        tick();
        chk("rm_pc1", 32'(pc_o), 1);
        tick(); tick(); tick();
        chk("rm_mem2", 32'(state_o), 4);
        rst = 1'b1;
        #1;
        chk("rm_rst_strb", strb(), 0);
        tick();
        chk("rm_state", 32'(state_o), 0);
        chk("rm_pc", 32'(pc_o), 0);
        chk("rm_cnt", 32'(retired_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
